// File: rtl/fsm_input_arbiter.sv
// Round-robin arbiter that lends one shared 2-input FSM to NREQ requesters,
// drives each winner's (a,b) burst, lets the FSM settle and returns its state.
module fsm_input_arbiter #(
  parameter int NREQ       = 4,
  parameter int STATE_W    = 4,
  parameter int LEN_W      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_a,
  input  logic [NREQ-1:0]       req_b,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [STATE_W-1:0]    fsm_state,
  output logic                  fsm_a,
  output logic                  fsm_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [STATE_W-1:0]    resp_state,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (LEN_W > SET_W) ? LEN_W : SET_W;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NREQ-1:0]    gnt_n, done_n;
  logic [STATE_W-1:0] resp_n;
  logic               fsm_a_n, fsm_b_n, busy_n;

  logic               found;
  logic [PTR_W-1:0]   win, cand_p;
  int unsigned        cand;
  logic [LEN_W-1:0]   win_len;

  // Winner search starts at rr_ptr and wraps modulo NREQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    cand   = 0;
    cand_p = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand   = (32'(rr_ptr) + i) % NREQ;
      cand_p = PTR_W'(cand);
      if (!found && req[cand_p]) begin
        found = 1'b1;
        win   = cand_p;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    done_n  = '0;
    resp_n  = resp_state;
    fsm_a_n = fsm_a;
    fsm_b_n = fsm_b;
    busy_n  = busy;
    win_len = req_len[win*LEN_W +: LEN_W];
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = DRIVE;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          busy_n     = 1'b1;
          fsm_a_n    = req_a[win];
          fsm_b_n    = req_b[win];
          cnt_n      = (win_len == '0) ? CNT_W'(1) : CNT_W'(win_len);
          ptr_n      = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt <= CNT_W'(1)) begin
          state_n = SETTLE;
          fsm_a_n = 1'b0;
          fsm_b_n = 1'b0;
          cnt_n   = CNT_W'(SETTLE_CYC);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt <= CNT_W'(1)) begin
          state_n = DONE;
          resp_n  = fsm_state;
          done_n  = gnt;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
        fsm_a_n = 1'b0;
        fsm_b_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      resp_state <= '0;
      fsm_a      <= 1'b0;
      fsm_b      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= ptr_n;
      cnt        <= cnt_n;
      gnt        <= gnt_n;
      done       <= done_n;
      resp_state <= resp_n;
      fsm_a      <= fsm_a_n;
      fsm_b      <= fsm_b_n;
      busy       <= busy_n;
    end
  end

  a_gnt_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done));
  a_done_gnt:    assert property (@(posedge clk) disable iff (!rst) (done & ~gnt) == '0);
  a_idle_quiet:  assert property (@(posedge clk) disable iff (!rst)
                                  (gnt == '0) |-> (!fsm_a && !fsm_b));

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// Self-checking bench for fsm_input_arbiter: directed vector table, hand
// sequences for reset/boundary cases, then random traffic vs a burst-level model.
module tb_fsm_input_arbiter;
  localparam int NREQ = 4, STATE_W = 4, LEN_W = 3, SETTLE_CYC = 1;

  logic                  clk = 1'b0, clk_en = 1'b1, rst = 1'b0;
  logic [NREQ-1:0]       req = '0, req_a = '0, req_b = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [STATE_W-1:0]    fsm_state = '0;
  logic                  fsm_a, fsm_b, busy;
  logic [NREQ-1:0]       gnt, done;
  logic [STATE_W-1:0]    resp_state;

  int n_cmp = 0, n_bad = 0;

  fsm_input_arbiter #(.NREQ(NREQ), .STATE_W(STATE_W), .LEN_W(LEN_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_len(req_len),
    .fsm_state(fsm_state), .fsm_a(fsm_a), .fsm_b(fsm_b), .gnt(gnt), .done(done),
    .resp_state(resp_state), .busy(busy));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       a;
    logic [NREQ-1:0]       b;
    logic [NREQ*LEN_W-1:0] len;
    int unsigned           win;
    int unsigned           eff_len;
  } vec_t;

  vec_t tbl[8];
  bit   exp_a[5]    = '{1, 1, 1, 0, 0};
  bit   exp_done[5] = '{0, 0, 0, 0, 1};

  // Apply one request record and follow the whole grant window.
  task automatic run_entry(input vec_t v, input logic [STATE_W-1:0] st);
    int unsigned gcyc = 0, dcnt = 0;
    bit seen = 0;
    logic [NREQ-1:0] first_g = '0, dval = '0;
    logic fa = 0, fb = 0;
    req = v.req; req_a = v.a; req_b = v.b; req_len = v.len; fsm_state = st;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        if (!seen) begin
          first_g = gnt; fa = fsm_a; fb = fsm_b; seen = 1;
        end
        gcyc++;
        if (done != '0) begin
          dcnt++; dval = done;
        end
      end else if (seen) begin
        break;
      end
    end
    check("tbl_winner",   32'(first_g), 32'(1) << v.win);
    check("tbl_fsm_a",    32'(fa), 32'(v.a[v.win]));
    check("tbl_fsm_b",    32'(fb), 32'(v.b[v.win]));
    check("tbl_gnt_cyc",  gcyc, v.eff_len + SETTLE_CYC + 1);
    check("tbl_done_cnt", dcnt, 1);
    check("tbl_done_bit", 32'(dval), 32'(1) << v.win);
    check("tbl_resp",     32'(resp_state), 32'(st));
    check("tbl_idle_busy", 32'(busy), 0);
  endtask

  // Burst-level reference: a grant occupies offsets 0..len+SETTLE_CYC.
  bit              m_act, m_a, m_b;
  int unsigned     m_j, m_L, m_w, m_ptr;
  logic [STATE_W-1:0] m_resp;

  task automatic model_step();
    int unsigned l;
    if (!rst) begin
      m_act = 0; m_ptr = 0; m_resp = '0; m_j = 0;
    end else if (m_act) begin
      m_j++;
      if (m_j == m_L + SETTLE_CYC) m_resp = fsm_state;
      else if (m_j > m_L + SETTLE_CYC) m_act = 0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        int unsigned c;
        c = (m_ptr + i) % NREQ;
        if (!m_act && req[c]) begin
          m_act = 1; m_w = c;
        end
      end
      if (m_act) begin
        m_j = 0;
        l = 32'(req_len[m_w*LEN_W +: LEN_W]);
        m_L = (l == 0) ? 1 : l;
        m_a = req_a[m_w]; m_b = req_b[m_w];
        m_ptr = (m_w + 1) % NREQ;
      end
    end
  endtask

  initial begin
    tbl[0] = '{req: 4'b1111, a: 4'b1010, b: 4'b0101, len: 12'h249, win: 0, eff_len: 1};
    tbl[1] = '{req: 4'b1111, a: 4'b1010, b: 4'b0101, len: 12'h249, win: 1, eff_len: 1};
    tbl[2] = '{req: 4'b1111, a: 4'b0100, b: 4'b0011, len: 12'h249, win: 2, eff_len: 1};
    tbl[3] = '{req: 4'b1111, a: 4'b1000, b: 4'b0000, len: 12'h249, win: 3, eff_len: 1};
    tbl[4] = '{req: 4'b1111, a: 4'b0001, b: 4'b0001, len: 12'h249, win: 0, eff_len: 1};
    tbl[5] = '{req: 4'b0100, a: 4'b0100, b: 4'b0000, len: 12'h000, win: 2, eff_len: 1};
    tbl[6] = '{req: 4'b0101, a: 4'b0000, b: 4'b0001, len: 12'h005, win: 0, eff_len: 5};
    tbl[7] = '{req: 4'b0100, a: 4'b0000, b: 4'b0100, len: 12'h1C0, win: 2, eff_len: 7};

    // Reset held with all requesters asking.
    rst = 0; req = 4'b1111; req_a = 4'b1111; req_b = 4'b1111; req_len = 12'h249;
    #20;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_fsm_a", 32'(fsm_a), 0);
    check("rst_fsm_b", 32'(fsm_b), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_resp", 32'(resp_state), 0);
    @(negedge clk);
    req = '0; rst = 1;

    for (int unsigned e = 0; e < 8; e++) run_entry(tbl[e], STATE_W'(e + 3));

    // Single len=3 burst; inputs changed and req dropped after the grant.
    req = 4'b0001; req_a = 4'b0001; req_b = 4'b0000; req_len = 12'h003; fsm_state = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_fsm_a", 32'(fsm_a), 32'(exp_a[i]));
      check("single_fsm_b", 32'(fsm_b), 0);
      check("single_done", 32'(done), exp_done[i] ? 32'h1 : 32'h0);
      check("single_busy", 32'(busy), 1);
      if (i == 0) begin
        req = '0; req_a = 4'b0000; req_b = 4'b0001; req_len = 12'h007; fsm_state = 4'b0110;
        fsm_state = 4'b0001;
      end
    end
    @(negedge clk);
    check("single_end_gnt", 32'(gnt), 0);
    check("single_end_busy", 32'(busy), 0);
    check("single_resp", 32'(resp_state), 32'h1);

    // Reset in the second DRIVE cycle of a len=5 burst, clock stopped.
    req = 4'b0100; req_a = 4'b0100; req_b = '0; req_len = 12'h140; fsm_state = 4'h9;
    @(negedge clk);
    check("midrst_grant", 32'(gnt), 32'h4);
    @(negedge clk);
    check("midrst_drive2_gnt", 32'(gnt), 32'h4);
    check("midrst_drive2_a", 32'(fsm_a), 1);
    req = 4'b1100;
    clk_en = 0;
    #2 rst = 0;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_fsm_a", 32'(fsm_a), 0);
    check("midrst_resp", 32'(resp_state), 0);
    #5 rst = 1;
    #2 clk_en = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("midrst_restart_winner", 32'(gnt), 32'h4);
    req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("midrst_drain_busy", 32'(busy), 0);

    // Random traffic with occasional async resets against the model.
    m_act = 0; m_ptr = 0; m_resp = '0; m_j = 0; m_L = 1; m_w = 0; m_a = 0; m_b = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst       = (cyc == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      req       = NREQ'($urandom);
      req_a     = NREQ'($urandom);
      req_b     = NREQ'($urandom);
      req_len   = (NREQ*LEN_W)'($urandom);
      fsm_state = STATE_W'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rnd_gnt",   32'(gnt),  m_act ? (32'(1) << m_w) : 0);
      check("rnd_done",  32'(done), (m_act && m_j == m_L + SETTLE_CYC) ? (32'(1) << m_w) : 0);
      check("rnd_fsm_a", 32'(fsm_a), (m_act && m_j < m_L) ? 32'(m_a) : 0);
      check("rnd_fsm_b", 32'(fsm_b), (m_act && m_j < m_L) ? 32'(m_b) : 0);
      check("rnd_busy",  32'(busy), 32'(m_act));
      check("rnd_resp",  32'(resp_state), 32'(m_resp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_input_arbiter.md
Name: fsm_input_arbiter

Overview:
- Shares one 2-input state machine (inputs a/b, 4-bit state output) among NREQ requesters.
- Each requester asks to drive an (a,b) pattern for a burst of cycles.
- The arbiter grants round-robin, drives the FSM inputs, waits for the state to settle, then returns the captured FSM state to the winner with a one-cycle done pulse.
- Sits between the test/control requesters and the shared state_machine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STATE_W, 4, width of the FSM state bus.
- LEN_W, 3, width of each requester's burst-length field.
- SETTLE_CYC, 1, cycles with a=b=0 after a burst before the state is captured (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester request level.
- req_a  input  NREQ  per-requester value to drive on FSM input a.
- req_b  input  NREQ  per-requester value to drive on FSM input b.
- req_len  input  NREQ*LEN_W  per-requester burst length; requester i occupies bits [i*LEN_W +: LEN_W].
- fsm_state  input  STATE_W  state output of the shared FSM.
- fsm_a  output  1  drives FSM input a.
- fsm_b  output  1  drives FSM input b.
- gnt  output  NREQ  one-hot grant; all-zero when idle.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- resp_state  output  STATE_W  FSM state captured at burst end; held until the next capture.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- rst=0 takes effect immediately, regardless of clk: state=IDLE, fsm_a=fsm_b=0, gnt=0, done=0, resp_state=0, busy=0, rr_ptr=0, internal counters=0.
- States: IDLE, DRIVE, SETTLE, DONE.
- IDLE:
  - If any req is 1 at a clock edge, the winner is chosen and the block enters DRIVE on that edge.
  - Winner = first requester with req=1, searching upward from rr_ptr with modulo-NREQ wrap.
  - On the same edge: gnt[winner]=1, busy=1, fsm_a/fsm_b=req_a/req_b[winner], burst count loaded from req_len[winner].
  - req_len=0 is treated as 1.
  - rr_ptr updates to (winner+1) mod NREQ.
- DRIVE:
  - fsm_a/fsm_b are held at the values latched at grant for exactly len cycles.
  - Later changes to req_a/req_b/req_len are ignored.
  - Then the block enters SETTLE, with fsm_a=fsm_b=0.
- SETTLE:
  - Lasts SETTLE_CYC cycles, with fsm_a=fsm_b=0.
  - On the edge leaving SETTLE: resp_state<=fsm_state, done[winner]<=1, and the block enters DONE.
- DONE:
  - One cycle; gnt is still asserted.
  - On exit: done=0, gnt=0, busy=0, back to IDLE.
- A new grant needs at least one IDLE cycle after DONE.
- Total occupancy per request = len+SETTLE_CYC+1 cycles of gnt.
- Requester behaviour:
  - A requester should hold req until it sees done.
  - If req drops mid-burst, the burst still completes and done still pulses.
  - A requester that keeps req high after done is eligible again only after every other active requester has been served.
- Simultaneous requests: exactly one winner per arbitration; the others wait with no lost requests.
- rr_ptr wrap: pointer NREQ-1 advances to 0.
- Reset during DRIVE/SETTLE/DONE aborts the burst: no done pulse, and resp_state is cleared.
- Invariants (checked by assertions):
  - gnt and done are always one-hot or zero.
  - done implies gnt at the same bit.
  - fsm_a/fsm_b are 0 whenever gnt==0.

Test Plan:
- Reset: hold rst=0 for 20 ns with req=4'b1111 → gnt=0, fsm_a=fsm_b=0, busy=0, done=0, resp_state=0. Async check: with clk stopped, drive rst low → outputs clear immediately.
- Single request: req=4'b0001, req_a[0]=1, req_b[0]=0, len=3, SETTLE_CYC=1 → gnt=4'b0001 for 5 cycles, fsm_a=1 for 3 cycles, then a=b=0. done[0] pulses once. resp_state equals the FSM state (4'b0001 with the team FSM) and matches fsm_state sampled at capture.
- Round robin: req=4'b1111, all len=1 → grant order 0,1,2,3,0. Exactly one done per grant; one idle cycle between grants.
- Pointer wrap and fairness: after serving requester 2, req=4'b0101 → requester 0 is granted before requester 2 (pointer=3 wraps to 0).
- Boundary: req_len=0 → one DRIVE cycle. req_a changes mid-burst → fsm_a unchanged. req dropped mid-burst → done still pulses.
- Reset mid-operation: assert rst=0 during the second DRIVE cycle of a len=5 burst → no done, gnt=0, resp_state=0. After release, the pending req is granted starting from requester 0.
